// File: rtl/output_port_arbiter.sv
// Round-robin output-port arbiter for one NoC switch port: filters requesters by
// destination range, grants bounded bursts, and registers the winning flit.
module output_port_arbiter #(
   parameter int DataWidth = 32,
   parameter int NumReq    = 3,
   parameter int DestMin   = 1,
   parameter int DestMax   = 1,
   parameter int MaxBurst  = 2
) (
   input  logic                          i_mclk,
   input  logic                          i_reset,
   input  logic [NumReq*DataWidth-1:0]   i_req_data,
   input  logic [NumReq-1:0]             i_req_valid,
   output logic [NumReq-1:0]             o_req_ready,
   output logic [DataWidth-1:0]          o_data,
   output logic                          o_data_valid,
   input  logic                          i_data_ready,
   output logic [$clog2(NumReq)-1:0]     o_owner,
   output logic [15:0]                   o_flit_count
);

   localparam int                 OwnW      = $clog2(NumReq);
   localparam int                 CntW      = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
   localparam logic [CntW-1:0]    BurstLast = CntW'(MaxBurst - 1);
   localparam logic [7:0]         DestLo    = 8'(DestMin);
   localparam logic [7:0]         DestHi    = 8'(DestMax);
   localparam logic [OwnW-1:0]    OwnerRst  = OwnW'(NumReq - 1);

   // Handshake: a requester flit moves when i_req_valid[i] & o_req_ready[i] are
   // both high at a rising edge; o_req_ready never depends on o_req_ready itself.
   // The output flit moves when o_data_valid & i_data_ready are both high, and
   // o_data/o_data_valid hold steady while o_data_valid=1 and i_data_ready=0.

   logic [NumReq-1:0]    elig;
   logic [CntW-1:0]      cnt;
   logic                 out_free;
   logic                 accept;
   logic                 hold;
   logic                 found;
   logic [OwnW-1:0]      winner;
   logic [DataWidth-1:0] win_flit;

   for (genvar g = 0; g < NumReq; g++) begin : g_elig
      logic [7:0] dest;
      assign dest    = i_req_data[g*DataWidth + DataWidth - 8 +: 8];
      assign elig[g] = i_req_valid[g] & (dest >= DestLo) & (dest <= DestHi);
   end

   assign out_free = ~o_data_valid | i_data_ready;
   assign accept   = ~i_reset & out_free & (|elig);

   // cnt never exceeds BurstLast, so inequality means the burst is still open.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = o_owner;
      hold   = elig[o_owner] && (cnt != BurstLast);
      if (hold) begin
         found = 1'b1;
      end else begin
         for (int k = 1; k <= NumReq; k++) begin
            idx = int'(o_owner) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!found && elig[idx]) begin
               found  = 1'b1;
               winner = OwnW'(idx);
            end
         end
      end
   end

   always_comb begin
      win_flit    = '0;
      o_req_ready = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (winner == OwnW'(i)) begin
            win_flit       = i_req_data[i*DataWidth +: DataWidth];
            o_req_ready[i] = accept & found;
         end
      end
   end

   always_ff @(posedge i_mclk or posedge i_reset) begin
      if (i_reset) begin
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_flit_count <= '0;
         o_owner      <= OwnerRst;
         cnt          <= '0;
      end else if (accept) begin
         o_data       <= win_flit;
         o_data_valid <= 1'b1;
         o_flit_count <= o_flit_count + 16'd1;
         if (winner == o_owner) begin
            if (cnt != BurstLast) cnt <= cnt + CntW'(1);
         end else begin
            o_owner <= winner;
            cnt     <= '0;
         end
      end else if (i_data_ready && o_data_valid) begin
         o_data_valid <= 1'b0;
      end
   end

   a_ready_onehot : assert property (@(posedge i_mclk) disable iff (i_reset)
      $onehot0(o_req_ready));

   a_stall_no_ready : assert property (@(posedge i_mclk) disable iff (i_reset)
      (o_data_valid && !i_data_ready) |-> (o_req_ready == '0));

endmodule
